control_sequencer: RTL and testbench

Parametrised hardwired control unit for the datapath. It replaces hand-sequenced control stimulus with an FSM that fetches an instruction and steps through its execute phase. It decodes the instruction register into the datapath's register-enable, tri-state-out and ALU-operation controls. It adds three behaviours the datapath did not have before: a memory-wait handshake, HI/LO writeback for mul/div, and run/stop/halt control.

---
 rtl/cpu_ctrl_pkg.sv | 58 +++++
 rtl/reg_field_decoder.sv | 18 +
 rtl/control_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, FSM states,
// instruction-field offsets and opcode classification.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        K_ALU3, K_UNARY, K_MULDIV, K_NOP, K_HALT, K_UNDEF
    } op_kind_t;

    // Fields are packed from the MSB down: opcode, Ra, Rb, Rc.
    function automatic int opc_lsb(input int dw, input int ow);
        return dw - ow;
    endfunction

    function automatic int ra_lsb(input int dw, input int ow, input int rw);
        return dw - ow - rw;
    endfunction

    function automatic int rb_lsb(input int dw, input int ow, input int rw);
        return dw - ow - 2 * rw;
    endfunction

    function automatic int rc_lsb(input int dw, input int ow, input int rw);
        return dw - ow - 3 * rw;
    endfunction

    function automatic op_kind_t classify(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:  return K_ALU3;
            OP_NEG, OP_NOT:                   return K_UNARY;
            OP_MUL, OP_DIV:                   return K_MULDIV;
            OP_NOP:                           return K_NOP;
            OP_HALT:                          return K_HALT;
            default:                          return K_UNDEF;
        endcase
    endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// Register-number to one-hot enable decoder; purely combinational, all-zero when disabled.
module reg_field_decoder #(
    parameter int IDX_W   = 4,
    parameter int NUM_OUT = 16
) (
    input  logic               en,
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_OUT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute control FSM: Moore outputs decoded from state plus IR, one state per cycle.
// Fetch stalls in T1 until mem_ready; Stop is honoured only at instruction boundaries.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int OPCODE_W   = 5
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] IR,
    input  logic                  Run,
    input  logic                  Stop,
    input  logic                  mem_ready,
    output logic                  PCout,
    output logic                  PCin,
    output logic                  IncPC,
    output logic                  MARin,
    output logic                  MDRin,
    output logic                  MDRout,
    output logic                  Read,
    output logic                  IRin,
    output logic                  Yin,
    output logic                  Zin,
    output logic                  Zlowout,
    output logic                  Zhighout,
    output logic                  HIin,
    output logic                  LOin,
    output logic [NUM_REGS-1:0]   Rin,
    output logic [NUM_REGS-1:0]   Rout,
    output logic [OPCODE_W-1:0]   operation,
    output logic                  Halted,
    output logic                  Illegal
);

    localparam int REG_W   = $clog2(NUM_REGS);
    localparam int OPC_LSB = opc_lsb(DATA_WIDTH, OPCODE_W);
    localparam int RA_LSB  = ra_lsb(DATA_WIDTH, OPCODE_W, REG_W);
    localparam int RB_LSB  = rb_lsb(DATA_WIDTH, OPCODE_W, REG_W);
    localparam int RC_LSB  = rc_lsb(DATA_WIDTH, OPCODE_W, REG_W);

    if ((NUM_REGS < 2) || ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : g_bad_num_regs
        $error("control_sequencer: NUM_REGS must be a power of 2 and at least 2");
    end
    if (OPCODE_W + 3 * REG_W > DATA_WIDTH) begin : g_bad_fields
        $error("control_sequencer: opcode and three register fields exceed DATA_WIDTH");
    end
    if (OPCODE_W < 5) begin : g_bad_opcode_w
        $error("control_sequencer: OPCODE_W must hold the 5-bit opcode set");
    end

    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    ra;
    logic [REG_W-1:0]    rb;
    logic [REG_W-1:0]    rc;
    op_kind_t            kind;

    assign opcode = IR[OPC_LSB +: OPCODE_W];
    assign ra     = IR[RA_LSB +: REG_W];
    assign rb     = IR[RB_LSB +: REG_W];
    assign rc     = IR[RC_LSB +: REG_W];

    if (RC_LSB > 0) begin : g_ir_low
        logic unused_ir_low;
        assign unused_ir_low = ^IR[RC_LSB-1:0];
    end

    // Any opcode bit above the defined 5-bit set makes the instruction undefined.
    assign kind = ((opcode >> 5) != '0) ? K_UNDEF : classify(opcode[4:0]);

    state_t state_q;
    state_t state_d;
    state_t ret_state;

    assign ret_state = Stop ? S_IDLE : S_T0;

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    logic             rin_en;
    logic             rout_en;
    logic [REG_W-1:0] rin_idx;
    logic [REG_W-1:0] rout_idx;

    always_comb begin
        state_d   = state_q;
        PCout     = 1'b0;
        PCin      = 1'b0;
        IncPC     = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        Read      = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        Halted    = 1'b0;
        Illegal   = 1'b0;
        rin_en    = 1'b0;
        rout_en   = 1'b0;
        rin_idx   = ra;
        rout_idx  = ra;
        operation = '0;

        case (state_q)
            S_IDLE: begin
                if (Run) state_d = ret_state;
            end
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                // Held while memory is slow; reloading PC from Z is harmless.
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) state_d = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                case (kind)
                    K_NOP:   state_d = ret_state;
                    K_HALT:  state_d = S_HALT;
                    default: state_d = S_T3;
                endcase
            end
            S_T3: begin
                case (kind)
                    K_ALU3: begin
                        rout_en  = 1'b1;
                        rout_idx = rb;
                        Yin      = 1'b1;
                        state_d  = S_T4;
                    end
                    K_UNARY: begin
                        rout_en  = 1'b1;
                        rout_idx = rb;
                        Zin      = 1'b1;
                        state_d  = S_T4;
                    end
                    K_MULDIV: begin
                        rout_en  = 1'b1;
                        rout_idx = ra;
                        Yin      = 1'b1;
                        state_d  = S_T4;
                    end
                    default: begin
                        Illegal = 1'b1;
                        state_d = ret_state;
                    end
                endcase
            end
            S_T4: begin
                case (kind)
                    K_ALU3: begin
                        rout_en  = 1'b1;
                        rout_idx = rc;
                        Zin      = 1'b1;
                        state_d  = S_T5;
                    end
                    K_UNARY: begin
                        Zlowout = 1'b1;
                        rin_en  = 1'b1;
                        rin_idx = ra;
                        state_d = ret_state;
                    end
                    K_MULDIV: begin
                        rout_en  = 1'b1;
                        rout_idx = rb;
                        Zin      = 1'b1;
                        state_d  = S_T5;
                    end
                    default: state_d = ret_state;
                endcase
            end
            S_T5: begin
                case (kind)
                    K_ALU3: begin
                        Zlowout = 1'b1;
                        rin_en  = 1'b1;
                        rin_idx = ra;
                        state_d = ret_state;
                    end
                    K_MULDIV: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                        state_d = S_T6;
                    end
                    default: state_d = ret_state;
                endcase
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = ret_state;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (Zin) operation = opcode;
    end

    reg_field_decoder #(
        .IDX_W   (REG_W),
        .NUM_OUT (NUM_REGS)
    ) u_rin_dec (
        .en     (rin_en),
        .idx    (rin_idx),
        .onehot (Rin)
    );

    reg_field_decoder #(
        .IDX_W   (REG_W),
        .NUM_OUT (NUM_REGS)
    ) u_rout_dec (
        .en     (rout_en),
        .idx    (rout_idx),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected control vectors queued with stimulus.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] IR = 32'd0;
    logic        Run = 1'b0;
    logic        Stop = 1'b0;
    logic        mem_ready = 1'b1;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin, Halted, Illegal;
    logic [15:0] Rin, Rout;
    logic [4:0]  operation;

    always #5 Clock = ~Clock;

    control_sequencer #(
        .DATA_WIDTH (32),
        .NUM_REGS   (16),
        .OPCODE_W   (5)
    ) dut (
        .Clock     (Clock),
        .clear     (clear),
        .IR        (IR),
        .Run       (Run),
        .Stop      (Stop),
        .mem_ready (mem_ready),
        .PCout     (PCout),
        .PCin      (PCin),
        .IncPC     (IncPC),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .Read      (Read),
        .IRin      (IRin),
        .Yin       (Yin),
        .Zin       (Zin),
        .Zlowout   (Zlowout),
        .Zhighout  (Zhighout),
        .HIin      (HIin),
        .LOin      (LOin),
        .Rin       (Rin),
        .Rout      (Rout),
        .operation (operation),
        .Halted    (Halted),
        .Illegal   (Illegal)
    );

    typedef struct packed {
        logic [15:0] ctl;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  op;
    } obs_t;

    typedef struct {
        logic [31:0] ir;
        logic        mr;
        logic        stop;
        obs_t        exp;
    } ent_t;

    localparam logic [15:0] C_PCOUT   = 16'h8000;
    localparam logic [15:0] C_PCIN    = 16'h4000;
    localparam logic [15:0] C_INCPC   = 16'h2000;
    localparam logic [15:0] C_MARIN   = 16'h1000;
    localparam logic [15:0] C_MDRIN   = 16'h0800;
    localparam logic [15:0] C_MDROUT  = 16'h0400;
    localparam logic [15:0] C_READ    = 16'h0200;
    localparam logic [15:0] C_IRIN    = 16'h0100;
    localparam logic [15:0] C_YIN     = 16'h0080;
    localparam logic [15:0] C_ZIN     = 16'h0040;
    localparam logic [15:0] C_ZLO     = 16'h0020;
    localparam logic [15:0] C_ZHI     = 16'h0010;
    localparam logic [15:0] C_HIIN    = 16'h0008;
    localparam logic [15:0] C_LOIN    = 16'h0004;
    localparam logic [15:0] C_HALTED  = 16'h0002;
    localparam logic [15:0] C_ILLEGAL = 16'h0001;

    localparam logic [15:0] T0X = C_PCOUT | C_MARIN | C_INCPC | C_ZIN;
    localparam logic [15:0] T1X = C_ZLO | C_PCIN | C_READ | C_MDRIN;
    localparam logic [15:0] T2X = C_MDROUT | C_IRIN;

    obs_t obs;
    assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
                  Yin, Zin, Zlowout, Zhighout, HIin, LOin, Halted, Illegal,
                  Rin, Rout, operation};

    ent_t q[$];
    int total = 0;
    int bad = 0;

    function automatic obs_t mk(input logic [15:0] ctl, input logic [15:0] rin,
                                input logic [15:0] rout, input logic [4:0] op);
        obs_t o;
        o.ctl  = ctl;
        o.rin  = rin;
        o.rout = rout;
        o.op   = op;
        return o;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] i);
        return 16'h0001 << i;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    task automatic push(input logic [31:0] ir, input logic mr, input logic stop, input obs_t e);
        ent_t x;
        x.ir   = ir;
        x.mr   = mr;
        x.stop = stop;
        x.exp  = e;
        q.push_back(x);
    endtask

    // Reference sequence of one instruction, from T0 to its last execute cycle.
    task automatic push_instr(input logic [31:0] ir, input int waits, input logic stop3);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = ir[31:27];
        ra = ir[26:23];
        rb = ir[22:19];
        rc = ir[18:15];
        push(ir, 1'b1, 1'b0, mk(T0X, '0, '0, op));
        for (int w = 0; w < waits; w++) push(ir, 1'b0, 1'b0, mk(T1X, '0, '0, 5'd0));
        push(ir, 1'b1, 1'b0, mk(T1X, '0, '0, 5'd0));
        push(ir, 1'b1, 1'b0, mk(T2X, '0, '0, 5'd0));
        if (op inside {[5'd3:5'd11]}) begin
            push(ir, 1'b1, stop3, mk(C_YIN, '0, oh(rb), 5'd0));
            push(ir, 1'b1, stop3, mk(C_ZIN, '0, oh(rc), op));
            push(ir, 1'b1, stop3, mk(C_ZLO, oh(ra), '0, 5'd0));
        end else if (op == 5'd17 || op == 5'd18) begin
            push(ir, 1'b1, stop3, mk(C_ZIN, '0, oh(rb), op));
            push(ir, 1'b1, stop3, mk(C_ZLO, oh(ra), '0, 5'd0));
        end else if (op == 5'd15 || op == 5'd16) begin
            push(ir, 1'b1, stop3, mk(C_YIN, '0, oh(ra), 5'd0));
            push(ir, 1'b1, stop3, mk(C_ZIN, '0, oh(rb), op));
            push(ir, 1'b1, stop3, mk(C_ZLO | C_LOIN, '0, '0, 5'd0));
            push(ir, 1'b1, stop3, mk(C_ZHI | C_HIIN, '0, '0, 5'd0));
        end else if (op != 5'd26 && op != 5'd27) begin
            push(ir, 1'b1, stop3, mk(C_ILLEGAL, '0, '0, 5'd0));
        end
    endtask

    task automatic do_reset();
        clear = 1'b0;
        Run = 1'b0;
        Stop = 1'b0;
        mem_ready = 1'b1;
        IR = 32'd0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        clear = 1'b1;
    endtask

    task automatic test_reset();
        ent_t e;
        int n;
        clear = 1'b1;
        #2 clear = 1'b0;
        #1;
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_async: got %h want 0", obs); end
        Run = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_held_run: got %h want 0", obs); end
        @(negedge Clock);
        clear = 1'b1;
        Stop = 1'b1;
        IR = mk_ir(5'b11010, 4'd0, 4'd0, 4'd0);
        push(IR, 1'b1, 1'b1, '0);
        push(IR, 1'b1, 1'b0, '0);
        push_instr(IR, 0, 1'b0);
        push(IR, 1'b1, 1'b0, mk(T0X, '0, '0, 5'b11010));
        n = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge Clock); #1;
            IR = e.ir; mem_ready = e.mr; Stop = e.stop; #1;
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL reset_run_stop cyc%0d: got %h want %h", n, obs, e.exp); end
            n++;
        end
    endtask

    task automatic test_and();
        ent_t e;
        int n;
        do_reset();
        IR = 32'h28918000;
        Run = 1'b1;
        push_instr(IR, 0, 1'b0);
        push(IR, 1'b1, 1'b0, mk(T0X, '0, '0, 5'b00101));
        n = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge Clock); #1;
            IR = e.ir; mem_ready = e.mr; Stop = e.stop; #1;
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL and_seq cyc%0d: got %h want %h", n + 1, obs, e.exp); end
            n++;
        end
    endtask

    task automatic test_mem_wait();
        ent_t e;
        int n;
        do_reset();
        IR = mk_ir(5'b00011, 4'd1, 4'd2, 4'd3);
        Run = 1'b1;
        push_instr(IR, 3, 1'b0);
        push(IR, 1'b1, 1'b0, mk(T0X, '0, '0, 5'b00011));
        n = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge Clock); #1;
            IR = e.ir; mem_ready = e.mr; Stop = e.stop; #1;
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL mem_wait cyc%0d: got %h want %h", n + 1, obs, e.exp); end
            n++;
        end
    endtask

    task automatic test_mul();
        ent_t e;
        int n;
        do_reset();
        IR = 32'h7A280000;
        Run = 1'b1;
        push_instr(IR, 0, 1'b0);
        push(IR, 1'b1, 1'b0, mk(T0X, '0, '0, 5'b01111));
        n = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge Clock); #1;
            IR = e.ir; mem_ready = e.mr; Stop = e.stop; #1;
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL mul_seq cyc%0d: got %h want %h", n + 1, obs, e.exp); end
            n++;
        end
    endtask

    task automatic test_halt();
        ent_t e;
        int n;
        do_reset();
        IR = mk_ir(5'b11011, 4'd0, 4'd0, 4'd0);
        Run = 1'b1;
        push_instr(IR, 0, 1'b0);
        repeat (4) push(IR, 1'b1, 1'b0, mk(C_HALTED, '0, '0, 5'd0));
        n = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge Clock); #1;
            IR = e.ir; mem_ready = e.mr; Stop = e.stop; #1;
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL halt_seq cyc%0d: got %h want %h", n + 1, obs, e.exp); end
            n++;
        end
        clear = 1'b0;
        #1;
        total++;
        if (obs !== '0) begin bad++; $display("FAIL halt_clear: got %h want 0", obs); end
        Run = 1'b0;
        #1 clear = 1'b1;
        @(posedge Clock); #1;
        total++;
        if (obs !== '0) begin bad++; $display("FAIL halt_to_idle: got %h want 0", obs); end
    endtask

    task automatic test_clear_mid();
        ent_t e;
        do_reset();
        IR = mk_ir(5'b00011, 4'd1, 4'd2, 4'd3);
        Run = 1'b1;
        push_instr(IR, 0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            e = q.pop_front();
            @(posedge Clock); #1;
            IR = e.ir; mem_ready = e.mr; Stop = e.stop; #1;
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL clear_mid_pre cyc%0d: got %h want %h", k + 1, obs, e.exp); end
        end
        q.delete();
        clear = 1'b0;
        #1;
        total++;
        if (obs !== '0) begin bad++; $display("FAIL clear_mid_now: got %h want 0", obs); end
        Run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) clear = 1'b1;
            @(posedge Clock); #1;
            total++;
            if (obs !== '0) begin bad++; $display("FAIL clear_mid_after cyc%0d: got %h want 0", k, obs); end
        end
    endtask

    task automatic test_stop();
        ent_t e;
        int n;
        do_reset();
        IR = mk_ir(5'b00100, 4'd6, 4'd14, 4'd15);
        Run = 1'b1;
        push_instr(IR, 0, 1'b1);
        push(IR, 1'b1, 1'b1, '0);
        push(IR, 1'b1, 1'b1, '0);
        n = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge Clock); #1;
            IR = e.ir; mem_ready = e.mr; Stop = e.stop; #1;
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL stop_seq cyc%0d: got %h want %h", n + 1, obs, e.exp); end
            n++;
        end
        Stop = 1'b0;
    endtask

    task automatic test_illegal();
        ent_t e;
        int n;
        do_reset();
        IR = mk_ir(5'b11111, 4'd3, 4'd4, 4'd5);
        Run = 1'b1;
        push_instr(IR, 0, 1'b0);
        push(IR, 1'b1, 1'b0, mk(T0X, '0, '0, 5'b11111));
        n = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge Clock); #1;
            IR = e.ir; mem_ready = e.mr; Stop = e.stop; #1;
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL illegal_seq cyc%0d: got %h want %h", n + 1, obs, e.exp); end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        ent_t e;
        int n;
        logic [31:0] prog [5];
        do_reset();
        prog[0] = mk_ir(5'b11010, 4'd0, 4'd0, 4'd0);
        prog[1] = mk_ir(5'b01011, 4'd15, 4'd0, 4'd7);
        prog[2] = mk_ir(5'b10001, 4'd7, 4'd9, 4'd0);
        prog[3] = mk_ir(5'b10000, 4'd2, 4'd3, 4'd0);
        prog[4] = mk_ir(5'b10010, 4'd0, 4'd11, 4'd0);
        for (int i = 0; i < 5; i++) push_instr(prog[i], i % 3, 1'b0);
        push(prog[0], 1'b1, 1'b0, mk(T0X, '0, '0, 5'b11010));
        IR = prog[0];
        Run = 1'b1;
        n = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge Clock); #1;
            IR = e.ir; mem_ready = e.mr; Stop = e.stop; #1;
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL back_to_back cyc%0d: got %h want %h", n + 1, obs, e.exp); end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_and();
        test_mem_wait();
        test_mul();
        test_halt();
        test_clear_mid();
        test_stop();
        test_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1);
    end

endmodule
